mem_bus_arbiter: RTL and testbench

Two-master arbiter sharing the single memory/IO bus between the RISC-V core (master 0) and a second bus master such as a DMA or debug loader (master 1). Sits between the masters and the MemoryController/IOController bus. Sequences each transfer with a fixed access latency, checks size and alignment, and returns read data with a one-cycle ack. Round-robin fairness applies when both masters request.

---
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/IO bus.
// Each transfer is latched at grant, held on the bus for LATENCY cycles, then acked for one cycle.
module mem_bus_arbiter #(
   parameter int LATENCY  = 2,
   parameter bit RST_LAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_rw,
   input  logic [1:0]  m0_size,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_rw,
   input  logic [1:0]  m1_size,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rw,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        grant_id
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          last_grant;
   logic          err_pend;

   logic          any_req;
   logic          win;
   logic [31:0]   sel_addr;
   logic [1:0]    sel_size;
   logic          req_err;
   logic          last_beat;

   // On a tie the master that did not win last time goes first.
   always_comb begin
      any_req   = m0_req | m1_req;
      win       = (m0_req && m1_req) ? ~last_grant : m1_req;
      sel_addr  = win ? m1_addr : m0_addr;
      sel_size  = win ? m1_size : m0_size;
      req_err   = (sel_size == 2'd3) ||
                  (sel_size == 2'd1 && sel_addr[0]) ||
                  (sel_size == 2'd2 && (sel_addr[1:0] != 2'b00));
      last_beat = (cnt == CW'(LATENCY - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = req_err ? DONE : ACCESS;
         ACCESS:  if (last_beat) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bus strobes and acks are decoded from state, so reset clears them immediately.
   always_comb begin
      mem_en = (state == ACCESS);
      busy   = (state != IDLE);
      m0_ack = (state == DONE) && !grant_id;
      m1_ack = (state == DONE) &&  grant_id;
      m0_err = m0_ack && err_pend;
      m1_err = m1_ack && err_pend;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         last_grant <= RST_LAST;
         err_pend   <= 1'b0;
         grant_id   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rw     <= 1'b0;
         mem_size   <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               grant_id   <= win;
               last_grant <= win;
               mem_addr   <= sel_addr;
               mem_wdata  <= win ? m1_wdata : m0_wdata;
               mem_rw     <= win ? m1_rw : m0_rw;
               mem_size   <= sel_size;
               err_pend   <= req_err;
               cnt        <= '0;
            end
            ACCESS: begin
               cnt <= cnt + 1'b1;
               if (last_beat && !mem_rw) begin
                  if (grant_id) m1_rdata <= mem_rdata;
                  else          m0_rdata <= mem_rdata;
               end
            end
            DONE: begin
               // Bus outputs return to zero once the transfer is retired.
               grant_id  <= 1'b0;
               err_pend  <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               mem_rw    <= 1'b0;
               mem_size  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random two-master traffic,
// all checked every cycle against a transaction-level timing model.
module tb_mem_bus_arbiter;

   localparam int LAT      = 2;
   localparam bit RST_LAST = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [1:0]  size  [2];
   logic [1:0]  rw = 2'b00;
   logic [31:0] mrd = '0;

   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_rw, busy, grant_id;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_size;

   mem_bus_arbiter #(.LATENCY(LAT), .RST_LAST(RST_LAST)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_rw(rw[0]), .m0_size(size[0]),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_rw(rw[1]), .m1_size(size[1]),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
      .mem_size(mem_size), .mem_rdata(mrd), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0, cyc = 0;
   bit auto_mode = 0, hold = 0, fix_rd = 0;
   bit pend [2];
   int ack_who [$];
   int ack_cyc [$];

   // Transaction model: one active transfer described by its grant edge and retire edge.
   bit          act = 0, last = RST_LAST;
   int          t_n, t_end;
   bit          t_w, t_err, t_rw;
   logic [31:0] t_addr, t_wdata;
   logic [1:0]  t_size;
   logic [31:0] exp_rd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      act = 0;
      last = RST_LAST;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
   endtask

   task automatic model_edge();
      if (!rst) return;
      if (act) begin
         if (!t_err && !t_rw && cyc == t_n + LAT) exp_rd[t_w] = mrd;
         if (cyc == t_end) act = 0;
      end else if (req != 2'b00) begin
         t_w     = (req == 2'b11) ? !last : req[1];
         last    = t_w;
         act     = 1;
         t_n     = cyc;
         t_addr  = addr[t_w];
         t_wdata = wdata[t_w];
         t_rw    = rw[t_w];
         t_size  = size[t_w];
         t_err   = (t_size == 2'd3) || ((t_addr % (32'd1 << t_size)) != 0);
         t_end   = cyc + (t_err ? 1 : LAT + 1);
      end
   endtask

   task automatic check_outputs();
      bit done;
      done = act && (cyc == t_end - 1);
      chk("busy",      32'(busy),      32'(act));
      chk("mem_en",    32'(mem_en),    32'(act && !t_err && cyc < t_n + LAT));
      chk("grant_id",  32'(grant_id),  32'(act && t_w));
      chk("m0_ack",    32'(m0_ack),    32'(done && !t_w));
      chk("m1_ack",    32'(m1_ack),    32'(done && t_w));
      chk("m0_err",    32'(m0_err),    32'(done && !t_w && t_err));
      chk("m1_err",    32'(m1_err),    32'(done && t_w && t_err));
      chk("mem_addr",  mem_addr,       act ? t_addr : 32'd0);
      chk("mem_wdata", mem_wdata,      act ? t_wdata : 32'd0);
      chk("mem_rw",    32'(mem_rw),    32'(act && t_rw));
      chk("mem_size",  32'(mem_size),  act ? 32'(t_size) : 32'd0);
      chk("m0_rdata",  m0_rdata,       exp_rd[0]);
      chk("m1_rdata",  m1_rdata,       exp_rd[1]);
      if (m0_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
      if (m1_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
      if (done) begin
         if (hold) pend[t_w] = 1;
         else begin
            pend[t_w] = 0;
            if (!auto_mode) req[t_w] = 1'b0;
         end
      end
   endtask

   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                        input bit w, input logic [1:0] s);
      addr[k] = a; wdata[k] = d; rw[k] = w; size[k] = s;
      req[k] = 1'b1; pend[k] = 1;
   endtask

   task automatic new_req(input int k);
      int r;
      logic [1:0] s;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % (32'd1 << s));
      issue(k, a, $urandom, 1'($urandom_range(0, 1)), s);
   endtask

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         if (!pend[k]) begin
            if ($urandom_range(0, 2) == 0) new_req(k);
            else req[k] = 1'b0;
         end else if (act && int'(t_w) == k) begin
            if (req[k] && $urandom_range(0, 7) == 0) req[k] = 1'b0;
         end else begin
            req[k] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (!fix_rd) mrd = $urandom;
      if (auto_mode) drive();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic wait_acks(input int n);
      int budget;
      budget = 100;
      while (ack_who.size() < n && budget > 0) begin
         step();
         budget--;
      end
      chk("ack_timeout", 32'(ack_who.size()), 32'(n));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      step();
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int b, g;
      logic [31:0] saved;
      for (int k = 0; k < 2; k++) begin
         addr[k] = '0; wdata[k] = '0; size[k] = '0; pend[k] = 0;
      end
      model_reset();
      step();
      step();
      rst = 1'b1;

      // Single word read.
      fix_rd = 1; mrd = 32'hDEADBEEF;
      b = ack_who.size(); g = cyc + 1;
      issue(0, 32'h100, 32'h0, 1'b0, 2'd2);
      wait_acks(b + 1);
      chk("single_rdata", m0_rdata, 32'hDEADBEEF);
      chk("single_err", 32'(m0_err), 32'd0);
      chk("single_lat", 32'(ack_cyc[b]), 32'(g + LAT));
      fix_rd = 0;

      // Tie right after reset: m0 first, then m1 four cycles later.
      do_reset();
      b = ack_who.size();
      issue(0, 32'h200, 32'h0, 1'b0, 2'd2);
      issue(1, 32'h300, 32'h12345678, 1'b1, 2'd2);
      wait_acks(b + 2);
      chk("tie_first", 32'(ack_who[b]), 32'd0);
      chk("tie_second", 32'(ack_who[b + 1]), 32'd1);
      chk("tie_gap", 32'(ack_cyc[b + 1] - ack_cyc[b]), 32'd4);

      // Continuous contention: strict alternation.
      step();
      hold = 1;
      b = ack_who.size();
      issue(0, 32'h400, 32'h0, 1'b0, 2'd1);
      issue(1, 32'h500, 32'hCAFE, 1'b1, 2'd0);
      wait_acks(b + 6);
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(ack_who[b + k]), 32'(k % 2));
      hold = 0; req = 2'b00; pend[0] = 0; pend[1] = 0;
      step(); step();

      // Misaligned word and reserved size on m1.
      saved = m1_rdata;
      b = ack_who.size(); g = cyc + 1;
      issue(1, 32'h102, 32'h0, 1'b0, 2'd2);
      wait_acks(b + 1);
      chk("misal_err", 32'(m1_err), 32'd1);
      chk("misal_lat", 32'(ack_cyc[b]), 32'(g));
      chk("misal_rdata", m1_rdata, saved);
      step();
      b = ack_who.size();
      issue(1, 32'h104, 32'h0, 1'b0, 2'd3);
      wait_acks(b + 1);
      chk("rsvd_err", 32'(m1_err), 32'd1);
      chk("rsvd_rdata", m1_rdata, saved);

      // Byte write leaves read data alone.
      step();
      saved = m0_rdata;
      b = ack_who.size();
      issue(0, 32'h3, 32'hA5, 1'b1, 2'd0);
      wait_acks(b + 1);
      chk("wr_err", 32'(m0_err), 32'd0);
      chk("wr_rdata", m0_rdata, saved);

      // Reset during the first bus cycle.
      step();
      issue(0, 32'h40, 32'h0, 1'b0, 2'd2);
      step();
      chk("pre_rst_en", 32'(mem_en), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack0", 32'(m0_ack), 32'd0);
      chk("rst_ack1", 32'(m1_ack), 32'd0);
      model_reset();
      req = 2'b00; pend[0] = 0; pend[1] = 0;
      step(); step();
      rst = 1'b1;
      b = ack_who.size();
      repeat (6) step();
      chk("rst_no_ack", 32'(ack_who.size()), 32'(b));
      issue(0, 32'h600, 32'h0, 1'b0, 2'd2);
      issue(1, 32'h700, 32'h0, 1'b0, 2'd2);
      wait_acks(b + 2);
      chk("rst_tie", 32'(ack_who[b]), 32'd0);
      step();

      // Random traffic from both masters.
      auto_mode = 1;
      repeat (3000) step();
      auto_mode = 0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
